systolic_feeder: RTL and testbench

- Upstream sequencer for the 2x2 int8 output-stationary systolic array (systolic_matrix).
- Accepts one A/B matrix pair per job over a valid/ready handshake, clears the array, and streams skewed operands with per-PE push strobes.
- After a drain wait, captures c11..c22 and presents the 2x2 int32 result over a valid/ready handshake.
- Exactly one job in flight.

---
 rtl/systolic_pkg.sv | 43 ++++
 rtl/systolic_feeder.sv | 220 ++++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types, constants and lane helpers for the systolic feeder.
// Lanes: int8 x4 in 32 bits, int32 x4 in 128 bits, element 11 at LSB.
package systolic_pkg;

    typedef logic signed [7:0]  int8_t;
    typedef logic signed [31:0] int32_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } feeder_state_e;

    localparam int          FEED_LEN = 4;
    localparam int unsigned N        = 2;

    // Row-major lane index, row/col 0-based.
    function automatic int unsigned lane_idx(
        input int unsigned r,
        input int unsigned c
    );
        return r * N + c;
    endfunction

    function automatic int8_t lane8(
        input logic [31:0] v,
        input int unsigned idx
    );
        return v[8*idx +: 8];
    endfunction

    function automatic logic [127:0] pack_c(
        input int32_t x11,
        input int32_t x12,
        input int32_t x21,
        input int32_t x22
    );
        return {x22, x21, x12, x11};
    endfunction

endpackage

// File: rtl/systolic_feeder.sv
// Job sequencer for the 2x2 int8 output-stationary systolic array.
// Ports: clk, reset (async, active-low); in_valid/in_ready/in_a/in_b job
// input; arr_reset, push11/pushedge/push22, a1X/a2X/bX1/bX2 array drive;
// c11..c22 array results; res_valid/res_ready/res_c result output.
// Optional macro SYSTOLIC_FEEDER_PERF_EN adds job_count and stall_cycles.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DRAIN_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_a,
    input  logic [31:0]  in_b,
    output logic         arr_reset,
    output logic         push11,
    output logic         pushedge,
    output logic         push22,
    output logic [7:0]   a1X,
    output logic [7:0]   a2X,
    output logic [7:0]   bX1,
    output logic [7:0]   bX2,
    input  logic [31:0]  c11,
    input  logic [31:0]  c12,
    input  logic [31:0]  c21,
    input  logic [31:0]  c22,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_c
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    output logic [15:0]  job_count,
    output logic [15:0]  stall_cycles
`endif
);

    feeder_state_e r_state, w_state;

    logic [1:0]   r_cnt, w_cnt;
    logic [3:0]   r_dcnt, w_dcnt;
    logic [31:0]  r_a, r_b;
    logic         r_arr_reset, w_arr_reset;
    logic         r_push11, r_pushedge, r_push22;
    logic [7:0]   r_a1X, r_a2X, r_bX1, r_bX2;
    logic         r_res_valid, w_res_valid;
    logic [127:0] r_res_c;

    logic         w_latch, w_capture, w_emit;
    logic [1:0]   w_slot;
    logic         w_p11, w_pe, w_p22;
    logic [7:0]   w_a1, w_a2, w_b1, w_b2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state;
    end

    // Outputs are registered, so each state computes the values
    // to be presented during the following cycle.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_dcnt      = r_dcnt;
        w_latch     = 1'b0;
        w_arr_reset = 1'b1;
        w_emit      = 1'b0;
        w_slot      = 2'd0;
        w_capture   = 1'b0;
        w_res_valid = r_res_valid;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_latch     = 1'b1;
                    w_arr_reset = 1'b0;
                    w_state     = CLEAR;
                end
            end
            CLEAR: begin
                w_state = FEED;
                w_cnt   = 2'd0;
                w_emit  = 1'b1;
                w_slot  = 2'd0;
            end
            FEED: begin
                w_cnt = r_cnt + 2'd1;
                if (r_cnt == 2'(FEED_LEN - 1)) begin
                    w_state = DRAIN;
                    w_dcnt  = 4'd0;
                end else begin
                    w_emit = 1'b1;
                    w_slot = r_cnt + 2'd1;
                end
            end
            DRAIN: begin
                if (r_dcnt == 4'(DRAIN_CYCLES - 1)) begin
                    w_capture   = 1'b1;
                    w_res_valid = 1'b1;
                    w_state     = DONE;
                end else begin
                    w_dcnt = r_dcnt + 4'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_res_valid = 1'b0;
                    w_state     = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Skewed operand schedule: slot t feeds the anti-diagonal t.
    always_comb begin
        w_p11 = 1'b0;
        w_pe  = 1'b0;
        w_p22 = 1'b0;
        w_a1  = 8'd0;
        w_a2  = 8'd0;
        w_b1  = 8'd0;
        w_b2  = 8'd0;
        if (w_emit) begin
            unique case (w_slot)
                2'd0: begin
                    w_p11 = 1'b1;
                    w_a1  = lane8(r_a, lane_idx(0, 0));
                    w_b1  = lane8(r_b, lane_idx(0, 0));
                end
                2'd1: begin
                    w_p11 = 1'b1;
                    w_pe  = 1'b1;
                    w_a1  = lane8(r_a, lane_idx(0, 1));
                    w_b1  = lane8(r_b, lane_idx(1, 0));
                    w_a2  = lane8(r_a, lane_idx(1, 0));
                    w_b2  = lane8(r_b, lane_idx(0, 1));
                end
                2'd2: begin
                    w_pe  = 1'b1;
                    w_p22 = 1'b1;
                    w_a2  = lane8(r_a, lane_idx(1, 1));
                    w_b2  = lane8(r_b, lane_idx(1, 1));
                end
                2'd3: begin
                    w_p22 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= 2'd0;
            r_dcnt      <= 4'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_arr_reset <= 1'b1;
            r_push11    <= 1'b0;
            r_pushedge  <= 1'b0;
            r_push22    <= 1'b0;
            r_a1X       <= 8'd0;
            r_a2X       <= 8'd0;
            r_bX1       <= 8'd0;
            r_bX2       <= 8'd0;
            r_res_valid <= 1'b0;
            r_res_c     <= 128'd0;
        end else begin
            r_cnt       <= w_cnt;
            r_dcnt      <= w_dcnt;
            r_arr_reset <= w_arr_reset;
            r_push11    <= w_p11;
            r_pushedge  <= w_pe;
            r_push22    <= w_p22;
            r_a1X       <= w_a1;
            r_a2X       <= w_a2;
            r_bX1       <= w_b1;
            r_bX2       <= w_b2;
            r_res_valid <= w_res_valid;
            if (w_latch) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            if (w_capture) r_res_c <= pack_c(c11, c12, c21, c22);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign arr_reset = r_arr_reset;
    assign push11    = r_push11;
    assign pushedge  = r_pushedge;
    assign push22    = r_push22;
    assign a1X       = r_a1X;
    assign a2X       = r_a2X;
    assign bX1       = r_bX1;
    assign bX2       = r_bX2;
    assign res_valid = r_res_valid;
    assign res_c     = r_res_c;

`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0] r_job_count, r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_job_count    <= 16'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (r_res_valid && res_ready)
                r_job_count <= r_job_count + 16'd1;
            if (r_res_valid && !res_ready && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign job_count    = r_job_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder with a behavioural 2x2 array model.
// Instance 0 uses DRAIN_CYCLES=1, instance 1 uses DRAIN_CYCLES=3.
module tb_systolic_feeder;

    logic clk = 1'b0;
    logic rst_n;

    logic         in_valid [2];
    logic         in_ready [2];
    logic [31:0]  in_a [2];
    logic [31:0]  in_b [2];
    logic         arr_n [2];
    logic         p11 [2];
    logic         pe [2];
    logic         p22 [2];
    logic [7:0]   a1X [2];
    logic [7:0]   a2X [2];
    logic [7:0]   bX1 [2];
    logic [7:0]   bX2 [2];
    logic [31:0]  c11 [2];
    logic [31:0]  c12 [2];
    logic [31:0]  c21 [2];
    logic [31:0]  c22 [2];
    logic         res_valid [2];
    logic         res_ready [2];
    logic [127:0] res_c [2];
`ifdef SYSTOLIC_FEEDER_PERF_EN
    logic [15:0]  job_count [2];
    logic [15:0]  stall_cycles [2];
`endif

    logic [7:0] f11a [2];
    logic [7:0] f11b [2];
    logic [7:0] f12b [2];
    logic [7:0] f21a [2];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    systolic_feeder u0 (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]),
        .arr_reset(arr_n[0]),
        .push11(p11[0]), .pushedge(pe[0]), .push22(p22[0]),
        .a1X(a1X[0]), .a2X(a2X[0]), .bX1(bX1[0]), .bX2(bX2[0]),
        .c11(c11[0]), .c12(c12[0]), .c21(c21[0]), .c22(c22[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_c(res_c[0])
`ifdef SYSTOLIC_FEEDER_PERF_EN
        , .job_count(job_count[0]), .stall_cycles(stall_cycles[0])
`endif
    );

    systolic_feeder #(.DRAIN_CYCLES(3)) u1 (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]),
        .arr_reset(arr_n[1]),
        .push11(p11[1]), .pushedge(pe[1]), .push22(p22[1]),
        .a1X(a1X[1]), .a2X(a2X[1]), .bX1(bX1[1]), .bX2(bX2[1]),
        .c11(c11[1]), .c12(c12[1]), .c21(c21[1]), .c22(c22[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_c(res_c[1])
`ifdef SYSTOLIC_FEEDER_PERF_EN
        , .job_count(job_count[1]), .stall_cycles(stall_cycles[1])
`endif
    );

    // Output-stationary 2x2 array: a flows right, b flows down.
    for (genvar g = 0; g < 2; g++) begin : g_arr
        always_ff @(posedge clk or negedge arr_n[g]) begin
            if (!arr_n[g]) begin
                c11[g] <= 0; c12[g] <= 0; c21[g] <= 0; c22[g] <= 0;
                f11a[g] <= 0; f11b[g] <= 0; f12b[g] <= 0; f21a[g] <= 0;
            end else begin
                if (p11[g]) begin
                    c11[g] <= c11[g] + int'($signed(a1X[g])) * int'($signed(bX1[g]));
                    f11a[g] <= a1X[g];
                    f11b[g] <= bX1[g];
                end
                if (pe[g]) begin
                    c12[g] <= c12[g] + int'($signed(f11a[g])) * int'($signed(bX2[g]));
                    f12b[g] <= bX2[g];
                    c21[g] <= c21[g] + int'($signed(a2X[g])) * int'($signed(f11b[g]));
                    f21a[g] <= a2X[g];
                end
                if (p22[g])
                    c22[g] <= c22[g] + int'($signed(f21a[g])) * int'($signed(f12b[g]));
            end
        end
    end

    typedef struct {
        logic [31:0]  a;
        logic [31:0]  b;
        logic [127:0] c;
    } vec_t;

    vec_t vecs [5];
    logic [36:0] tr_exp [6];

    function automatic logic [31:0] pk8(input int x11, x12, x21, x22);
        return {8'(x22), 8'(x21), 8'(x12), 8'(x11)};
    endfunction

    function automatic logic [127:0] pkc(input int x11, x12, x21, x22);
        return {32'(x22), 32'(x21), 32'(x12), 32'(x11)};
    endfunction

    function automatic logic [36:0] tw(input int ir, an, q1, qe, q2, a1, b1, a2, b2);
        return {1'(ir), 1'(an), 1'(q1), 1'(qe), 1'(q2),
                8'(a1), 8'(b1), 8'(a2), 8'(b2)};
    endfunction

    function automatic logic [36:0] trace(input int g);
        return {in_ready[g], arr_n[g], p11[g], pe[g], p22[g],
                a1X[g], bX1[g], a2X[g], bX2[g]};
    endfunction

    function automatic int drn(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic accept(input int g, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_valid[g] = 1'b1;
        in_a[g] = a;
        in_b[g] = b;
        while (!in_ready[g] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 128'(w < 50), 128'(1));
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_res(input int g, output int lat);
        lat = 0;
        while (!res_valid[g] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_job(input int g, input vec_t v, input int stall, input string nm);
        int lat;
        res_ready[g] = (stall == 0);
        accept(g, v.a, v.b);
        wait_res(g, lat);
        chk({nm, "_lat"}, 128'(lat), 128'(5 + drn(g)));
        chk({nm, "_c"}, res_c[g], v.c);
        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            chk({nm, "_hold"}, res_c[g], v.c);
            res_ready[g] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({nm, "_rvclr"}, 128'(res_valid[g]), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [36:0] rst_tr;

        vecs[0] = '{pk8(1, 2, 3, 4), pk8(5, 6, 7, 8), pkc(19, 22, 43, 50)};
        vecs[1] = '{pk8(-128, -128, 127, 0), pk8(-128, 0, -128, 1),
                    pkc(32768, -128, -16256, 0)};
        vecs[2] = '{pk8(-1, 2, 3, -4), pk8(5, -6, -7, 8), pkc(-19, 22, 43, -50)};
        vecs[3] = '{pk8(127, 127, 127, 127), pk8(127, 127, 127, 127),
                    pkc(32258, 32258, 32258, 32258)};
        vecs[4] = '{pk8(1, 0, 0, 1), pk8(5, 6, 7, 8), pkc(5, 6, 7, 8)};

        tr_exp[0] = tw(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tr_exp[1] = tw(0, 1, 1, 0, 0, 1, 5, 0, 0);
        tr_exp[2] = tw(0, 1, 1, 1, 0, 2, 7, 3, 6);
        tr_exp[3] = tw(0, 1, 0, 1, 1, 0, 0, 4, 8);
        tr_exp[4] = tw(0, 1, 0, 0, 1, 0, 0, 0, 0);
        tr_exp[5] = tw(0, 1, 0, 0, 0, 0, 0, 0, 0);
        rst_tr    = tw(1, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int g = 0; g < 2; g++) begin
            in_valid[g] = 1'b0;
            in_a[g] = 32'd0;
            in_b[g] = 32'd0;
            res_ready[g] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_tr", 128'(trace(g)), 128'(rst_tr));
            chk("rst_rv", 128'(res_valid[g]), 128'(0));
            chk("rst_c", res_c[g], 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Basic job with cycle-by-cycle operand/push trace.
        accept(0, vecs[0].a, vecs[0].b);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("trace_t%0d", i), 128'(trace(0)), 128'(tr_exp[i]));
            chk($sformatf("trace_rv%0d", i), 128'(res_valid[0]), 128'(0));
            @(posedge clk);
            #1;
        end
        chk("basic_rv", 128'(res_valid[0]), 128'(1));
        chk("basic_c", res_c[0], vecs[0].c);
        @(posedge clk);
        #1;
        chk("basic_rvclr", 128'(res_valid[0]), 128'(0));
        chk("basic_idle", 128'(in_ready[0]), 128'(1));

        for (int i = 0; i < 5; i++)
            for (int g = 0; g < 2; g++)
                run_job(g, vecs[i], 0, $sformatf("vec%0d_d%0d", i, drn(g)));

        // Back-pressure with a second job waiting.
        res_ready[0] = 1'b0;
        accept(0, vecs[0].a, vecs[0].b);
        wait_res(0, lat);
        chk("bp1_lat", 128'(lat), 128'(6));
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_a[0] = vecs[2].a;
        in_b[0] = vecs[2].b;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_c", res_c[0], vecs[0].c);
            chk("bp_hold_rdy", 128'(in_ready[0]), 128'(0));
            chk("bp_hold_rv", 128'(res_valid[0]), 128'(1));
            @(negedge clk);
        end
        res_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_xfer_rv", 128'(res_valid[0]), 128'(0));
        chk("bp_xfer_noacc", 128'(arr_n[0]), 128'(1));
        chk("bp_xfer_rdy", 128'(in_ready[0]), 128'(1));
        @(posedge clk);
        #1;
        chk("bp2_acc", 128'(arr_n[0]), 128'(0));
        in_valid[0] = 1'b0;
        wait_res(0, lat);
        chk("bp2_lat", 128'(lat), 128'(6));
        chk("bp2_c", res_c[0], vecs[2].c);
        @(posedge clk);
        #1;

        // Reset during FEED t=2.
        accept(0, vecs[1].a, vecs[1].b);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_t2", 128'(trace(0)), 128'(tr_exp[3] & ~37'hFF_FFFF) |
            128'(trace(0) & 37'hFF_FFFF));
        chk("mid_p22", 128'(p22[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tr", 128'(trace(0)), 128'(rst_tr));
        chk("mid_rst_rv", 128'(res_valid[0]), 128'(0));
        chk("mid_rst_c", res_c[0], 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_job(0, '{pk8(1, 0, 0, 1), pk8(1, 0, 0, 1), pkc(1, 0, 0, 1)}, 0, "post_rst");

`ifdef SYSTOLIC_FEEDER_PERF_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("perf_rst_jobs", 128'(job_count[0]), 128'(0));
        chk("perf_rst_stall", 128'(stall_cycles[0]), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_job(0, vecs[0], 0, "perf1");
        run_job(0, vecs[1], 4, "perf2");
        run_job(0, vecs[2], 0, "perf3");
        chk("perf_jobs", 128'(job_count[0]), 128'(3));
        chk("perf_stall", 128'(stall_cycles[0]), 128'(4));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
